// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset and watches the synchronized lock
// indication. Downstream logic is released only after lock has been stable for a
// while. A lock loss in RUN re-pulses the PLL reset, and repeated lock timeouts
// latch a fault that is left only when clear_fault is pulsed.
module pll_lock_supervisor #(
   parameter int unsigned RST_PULSE_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 16000,
   parameter int unsigned STABLE_CYCLES       = 256,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned CNT_W               = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       clear_fault,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [7:0] loss_count,
   output logic [2:0] state_o
);

   localparam int unsigned RET_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RET_W-1:0] RET_MAX     = RET_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StResetPll  = 3'd0,
      StWaitLock  = 3'd1,
      StStabilize = 3'd2,
      StRun       = 3'd3,
      StFault     = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RET_W-1:0] retries_q, retries_d;
   logic [7:0]       loss_q, loss_d;
   logic             lk_meta_q, lk_s_q;

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge refclk) begin
      if (rst) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
      end else begin
         lk_meta_q <= pll_locked;
         lk_s_q    <= lk_meta_q;
      end
   end

   // State register together with the shared counter, retry and loss counters.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= StResetPll;
         cnt_q     <= '0;
         retries_q <= '0;
         loss_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retries_q <= retries_d;
         loss_q    <= loss_d;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retries_d = retries_q;
      loss_d    = loss_q;
      case (state_q)
         StResetPll: begin
            if (cnt_q == RST_LAST) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StWaitLock: begin
            // Lock wins over a timeout landing on the same cycle.
            if (lk_s_q) begin
               state_d = StStabilize;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               cnt_d     = '0;
               retries_d = retries_q + RET_W'(1);
               if (retries_d == RET_MAX) begin
                  state_d = StFault;
               end else begin
                  state_d = StResetPll;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StStabilize: begin
            // A glitch here is not a timeout, so retries are left alone.
            if (!lk_s_q) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d   = StRun;
               cnt_d     = '0;
               retries_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StRun: begin
            if (!lk_s_q) begin
               state_d = StResetPll;
               cnt_d   = '0;
               if (loss_q != 8'hff) begin
                  loss_d = loss_q + 8'd1;
               end
            end
         end
         StFault: begin
            if (clear_fault) begin
               state_d   = StResetPll;
               cnt_d     = '0;
               retries_d = '0;
            end
         end
         default: begin
            state_d   = StResetPll;
            cnt_d     = '0;
            retries_d = '0;
         end
      endcase
   end

   // Outputs are pure decodes of the registered state.
   always_comb begin
      pll_rst = 1'b0;
      sys_rst = 1'b1;
      ready   = 1'b0;
      fault   = 1'b0;
      case (state_q)
         StResetPll: pll_rst = 1'b1;
         StRun: begin
            sys_rst = 1'b0;
            ready   = 1'b1;
         end
         StFault: begin
            pll_rst = 1'b1;
            fault   = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o    = state_q;
   assign loss_count = loss_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits on the consumer side of the 16 MHz PLL wrapper.
- Drives the PLL reset input and watches the PLL `locked` output.
- Holds the downstream logic in reset until lock has been continuously stable. On loss of lock it re-pulses the PLL reset and retries.
- Declares a fault after repeated lock timeouts; the fault clears only on command.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=1)
- LOCK_TIMEOUT_CYCLES, 16000: max refclk cycles to wait for lock per attempt (1 ms @ 16 MHz)
- STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before release
- MAX_RETRIES, 3: consecutive lock timeouts before FAULT (>=1)
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)

Ports:
- refclk, input, 1: free-running reference clock; only clock in the block
- rst, input, 1: synchronous, active-high reset
- pll_locked, input, 1: PLL `locked`, asynchronous to refclk
- clear_fault, input, 1: one-cycle pulse; leaves FAULT
- pll_rst, output, 1: reset to the PLL
- sys_rst, output, 1: reset to the logic clocked by the PLL output, active-high
- ready, output, 1: high only in RUN
- fault, output, 1: high only in FAULT
- loss_count, output, 8: number of RUN→lock-loss events; saturates at 255
- state_o, output, 3: current state encoding, for debug

Behaviour:
- Synchronizer:
  - pll_locked passes through two refclk flops to give lk_s.
  - Only lk_s is used internally.
  - Latency is 2 edges.
- Reset values (rst=1 sampled at an edge):
  - state=RESET_PLL, cnt=0, retries=0, loss_count=0, sync flops=0.
  - pll_rst=1, sys_rst=1, ready=0, fault=0.
- Outputs are pure decodes of the state register; there are no combinational paths from inputs.
  - pll_rst=1 in RESET_PLL and FAULT.
  - sys_rst=0 only in RUN.
  - ready=(RUN), fault=(FAULT).
- State encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.
- RESET_PLL:
  - cnt increments each edge.
  - When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK with cnt=0.
  - pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - If lk_s=1, go to STABILIZE with cnt=0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1, retries++. If the new retries==MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL with cnt=0.
  - Otherwise cnt++.
- STABILIZE:
  - If lk_s=0, go to WAIT_LOCK with cnt=0 and retries unchanged (lock glitch, not a timeout).
  - Else if cnt==STABLE_CYCLES-1, go to RUN with retries=0.
  - Otherwise cnt++.
- RUN:
  - If lk_s=0, go to RESET_PLL with cnt=0 and loss_count++ (saturating at 255).
  - sys_rst=1 from the next cycle.
- FAULT:
  - Remains here until clear_fault=1, then go to RESET_PLL with cnt=0 and retries=0.
  - lk_s is ignored while in FAULT.
  - loss_count is preserved.
- Simultaneous events:
  - rst dominates everything.
  - In WAIT_LOCK, lk_s=1 on the timeout cycle means lock wins: go to STABILIZE.
  - clear_fault outside FAULT is ignored.
- Reset mid-operation: any state returns to RESET_PLL on the next edge and loss_count clears.
- Release latency: pll_locked rising and held in WAIT_LOCK gives ready=1 after the (STABLE_CYCLES+3)th refclk edge that samples it high.

Test Plan (bench params RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Clean bring-up:
  - Stimulus: release rst, hold pll_locked=0 for 10 cycles, then hold it at 1.
  - Response: pll_rst high for exactly 4 cycles after release; ready and sys_rst=0 exactly 11 edges after the first high sample; state_o=3.
- Glitch in STABILIZE:
  - Stimulus: pll_locked high 5 cycles, low 3, then high.
  - Response: state returns to WAIT_LOCK, retries unchanged; ready rises 11 edges after the second rise; no pll_rst pulse.
- Timeout to fault:
  - Stimulus: pll_locked held 0.
  - Response: two pll_rst pulses of 4 cycles each, separated by 20-cycle waits; then fault=1 and pll_rst=1 held; state_o=4.
- Fault clear:
  - Stimulus: in FAULT, pulse clear_fault, then raise pll_locked.
  - Response: fault=0 next edge; pll_rst pulses 4 cycles; normal bring-up to ready.
- Loss in RUN:
  - Stimulus: in RUN, drop pll_locked 1 cycle, 3 separate times.
  - Response: each drop makes sys_rst=1 and ready=0 2–3 edges later, followed by a 4-cycle pll_rst pulse and re-lock; loss_count=3.
- Saturation and reset priority:
  - Stimulus: 260 loss events.
  - Response: loss_count=255.
  - Stimulus: assert rst mid-STABILIZE.
  - Response: state_o=0, loss_count=0, pll_rst=1 next edge.
